// File: rtl/dsp19x2_dot_seq.sv
// rtl/dsp19x2_dot_seq.sv - dot-product job sequencer for one DSP19X2 in multiply-accumulate mode
module dsp19x2_dot_seq #(
    parameter int LEN_W       = 8,
    parameter int DSP_LATENCY = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [4:0]       cmd_shift,
    input  logic             cmd_round,
    input  logic             cmd_saturate,
    input  logic             cmd_subtract,
    input  logic             cmd_unsigned_a,
    input  logic             cmd_unsigned_b,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [9:0]       op_a1,
    input  logic [9:0]       op_a2,
    input  logic [8:0]       op_b1,
    input  logic [8:0]       op_b2,
    output logic [9:0]       dsp_a1,
    output logic [9:0]       dsp_a2,
    output logic [8:0]       dsp_b1,
    output logic [8:0]       dsp_b2,
    output logic [2:0]       dsp_feedback,
    output logic             dsp_load_acc,
    output logic [4:0]       dsp_acc_fir,
    output logic [4:0]       dsp_shift_right,
    output logic             dsp_round,
    output logic             dsp_saturate,
    output logic             dsp_subtract,
    output logic             dsp_unsigned_a,
    output logic             dsp_unsigned_b,
    input  logic [18:0]      dsp_z1,
    input  logic [18:0]      dsp_z2,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [18:0]      res_z1,
    output logic [18:0]      res_z2,
    output logic             busy
);

    localparam int CNT_W = (DSP_LATENCY < 1) ? 1 : $clog2(DSP_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] remaining_q;
    logic [CNT_W-1:0] cnt_q;
    logic             first_q;
    logic [9:0]       a1_q, a2_q;
    logic [8:0]       b1_q, b2_q;
    logic [2:0]       feedback_q;
    logic             load_acc_q;
    logic [4:0]       shift_q;
    logic             round_q, saturate_q, subtract_q, unsigned_a_q, unsigned_b_q;
    logic [18:0]      z1_q, z2_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid) state_d = (cmd_len != '0) ? RUN : HOLD;
            RUN:     if (op_valid && remaining_q == LEN_W'(1)) state_d = DRAIN;
            DRAIN:   if (cnt_q == '0) state_d = HOLD;
            HOLD:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == IDLE);
        op_ready  = (state_q == RUN);
        res_valid = (state_q == HOLD);
        busy      = (state_q != IDLE);
    end

    // Mode bits stay put from latch to the next latch: the DSP pipelines
    // shift/round/saturate internally and samples them late.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            remaining_q  <= '0;
            cnt_q        <= '0;
            first_q      <= 1'b0;
            a1_q         <= '0;
            a2_q         <= '0;
            b1_q         <= '0;
            b2_q         <= '0;
            feedback_q   <= '0;
            load_acc_q   <= 1'b0;
            shift_q      <= '0;
            round_q      <= 1'b0;
            saturate_q   <= 1'b0;
            subtract_q   <= 1'b0;
            unsigned_a_q <= 1'b1;
            unsigned_b_q <= 1'b1;
            z1_q         <= '0;
            z2_q         <= '0;
        end else begin
            load_acc_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        shift_q      <= cmd_shift;
                        round_q      <= cmd_round;
                        saturate_q   <= cmd_saturate;
                        subtract_q   <= cmd_subtract;
                        unsigned_a_q <= cmd_unsigned_a;
                        unsigned_b_q <= cmd_unsigned_b;
                        remaining_q  <= cmd_len;
                        first_q      <= 1'b1;
                        if (cmd_len == '0) begin
                            z1_q <= '0;
                            z2_q <= '0;
                        end
                    end
                end
                RUN: begin
                    if (op_valid) begin
                        a1_q        <= op_a1;
                        a2_q        <= op_a2;
                        b1_q        <= op_b1;
                        b2_q        <= op_b2;
                        load_acc_q  <= 1'b1;
                        feedback_q  <= first_q ? 3'b001 : 3'b000;
                        first_q     <= 1'b0;
                        remaining_q <= remaining_q - LEN_W'(1);
                        if (remaining_q == LEN_W'(1)) cnt_q <= CNT_W'(DSP_LATENCY);
                    end
                end
                DRAIN: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        z1_q <= dsp_z1;
                        z2_q <= dsp_z2;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dsp_a1          = a1_q;
    assign dsp_a2          = a2_q;
    assign dsp_b1          = b1_q;
    assign dsp_b2          = b2_q;
    assign dsp_feedback    = feedback_q;
    assign dsp_load_acc    = load_acc_q;
    assign dsp_acc_fir     = 5'd0;
    assign dsp_shift_right = shift_q;
    assign dsp_round       = round_q;
    assign dsp_saturate    = saturate_q;
    assign dsp_subtract    = subtract_q;
    assign dsp_unsigned_a  = unsigned_a_q;
    assign dsp_unsigned_b  = unsigned_b_q;
    assign res_z1          = z1_q;
    assign res_z2          = z2_q;

endmodule

// File: tb/tb_dsp19x2_dot_seq.sv
// tb/tb_dsp19x2_dot_seq.sv - self-checking bench for dsp19x2_dot_seq with a behavioural DSP19X2 MAC model
module tb_dsp19x2_dot_seq;

    localparam int LEN_W       = 8;
    localparam int DSP_LATENCY = 3;

    logic             CLK = 1'b0;
    logic             RESET = 1'b1;
    logic             cmd_valid = 1'b0, cmd_ready;
    logic [LEN_W-1:0] cmd_len = '0;
    logic [4:0]       cmd_shift = '0;
    logic             cmd_round = 1'b0, cmd_saturate = 1'b0, cmd_subtract = 1'b0;
    logic             cmd_unsigned_a = 1'b1, cmd_unsigned_b = 1'b1;
    logic             op_valid = 1'b0, op_ready;
    logic [9:0]       op_a1 = '0, op_a2 = '0;
    logic [8:0]       op_b1 = '0, op_b2 = '0;
    logic [9:0]       dsp_a1, dsp_a2;
    logic [8:0]       dsp_b1, dsp_b2;
    logic [2:0]       dsp_feedback;
    logic             dsp_load_acc;
    logic [4:0]       dsp_acc_fir, dsp_shift_right;
    logic             dsp_round, dsp_saturate, dsp_subtract, dsp_unsigned_a, dsp_unsigned_b;
    logic [18:0]      dsp_z1, dsp_z2;
    logic             res_valid, res_ready = 1'b0;
    logic [18:0]      res_z1, res_z2;
    logic             busy;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    dsp19x2_dot_seq #(.LEN_W(LEN_W), .DSP_LATENCY(DSP_LATENCY)) dut (
        .CLK(CLK), .RESET(RESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_shift(cmd_shift),
        .cmd_round(cmd_round), .cmd_saturate(cmd_saturate), .cmd_subtract(cmd_subtract),
        .cmd_unsigned_a(cmd_unsigned_a), .cmd_unsigned_b(cmd_unsigned_b),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a1(op_a1), .op_a2(op_a2), .op_b1(op_b1), .op_b2(op_b2),
        .dsp_a1(dsp_a1), .dsp_a2(dsp_a2), .dsp_b1(dsp_b1), .dsp_b2(dsp_b2),
        .dsp_feedback(dsp_feedback), .dsp_load_acc(dsp_load_acc), .dsp_acc_fir(dsp_acc_fir),
        .dsp_shift_right(dsp_shift_right), .dsp_round(dsp_round), .dsp_saturate(dsp_saturate),
        .dsp_subtract(dsp_subtract), .dsp_unsigned_a(dsp_unsigned_a), .dsp_unsigned_b(dsp_unsigned_b),
        .dsp_z1(dsp_z1), .dsp_z2(dsp_z2),
        .res_valid(res_valid), .res_ready(res_ready), .res_z1(res_z1), .res_z2(res_z2),
        .busy(busy)
    );

    // DSP19X2 MAC model: input register, accumulator, Z register.
    function automatic longint mul(input logic [9:0] a, input logic [8:0] b, input logic ua, input logic ub);
        longint ae, be;
        ae = ua ? longint'(a) : longint'($signed(a));
        be = ub ? longint'(b) : longint'($signed(b));
        return ae * be;
    endfunction

    function automatic logic [18:0] zfmt(input longint acc, input logic [4:0] sh, input logic rnd,
                                         input logic sat, input logic uns);
        longint r;
        r = acc;
        if (rnd && sh != 0) r = r + (longint'(1) <<< (sh - 1));
        r = r >>> sh;
        if (sat) begin
            if (uns) begin
                if (r < 0) r = 0;
                else if (r > 524287) r = 524287;
            end else begin
                if (r < -262144) r = -262144;
                else if (r > 262143) r = 262143;
            end
        end
        return r[18:0];
    endfunction

    logic [9:0]  s_a1, s_a2;
    logic [8:0]  s_b1, s_b2;
    logic [2:0]  s_fb;
    logic [4:0]  s_sh;
    logic        s_ld, s_sub, s_rnd, s_sat, s_ua, s_ub;
    longint      acc1, acc2;
    logic [18:0] m_z1, m_z2;

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s_a1 <= '0; s_a2 <= '0; s_b1 <= '0; s_b2 <= '0; s_fb <= '0; s_sh <= '0;
            s_ld <= 1'b0; s_sub <= 1'b0; s_rnd <= 1'b0; s_sat <= 1'b0; s_ua <= 1'b1; s_ub <= 1'b1;
            acc1 <= 0; acc2 <= 0; m_z1 <= '0; m_z2 <= '0;
        end else begin
            s_a1 <= dsp_a1; s_a2 <= dsp_a2; s_b1 <= dsp_b1; s_b2 <= dsp_b2;
            s_fb <= dsp_feedback; s_ld <= dsp_load_acc; s_sh <= dsp_shift_right;
            s_sub <= dsp_subtract; s_rnd <= dsp_round; s_sat <= dsp_saturate;
            s_ua <= dsp_unsigned_a; s_ub <= dsp_unsigned_b;
            if (s_ld) begin
                acc1 <= ((s_fb == 3'd1) ? 0 : acc1) + (s_sub ? -mul(s_a1, s_b1, s_ua, s_ub) : mul(s_a1, s_b1, s_ua, s_ub));
                acc2 <= ((s_fb == 3'd1) ? 0 : acc2) + (s_sub ? -mul(s_a2, s_b2, s_ua, s_ub) : mul(s_a2, s_b2, s_ua, s_ub));
            end
            m_z1 <= zfmt(acc1, s_sh, s_rnd, s_sat, s_ua & s_ub);
            m_z2 <= zfmt(acc2, s_sh, s_rnd, s_sat, s_ua & s_ub);
        end
    end
    assign dsp_z1 = m_z1;
    assign dsp_z2 = m_z2;

    typedef struct {
        int          len;
        logic [4:0]  sh;
        logic        rnd, sat, sub, ua, ub;
        int          gap;
        logic [9:0]  a1 [4];
        logic [9:0]  a2 [4];
        logic [8:0]  b1 [4];
        logic [8:0]  b2 [4];
        logic [18:0] z1, z2;
    } job_t;

    job_t tbl [6];
    job_t j;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_job(input job_t jb, input string nm);
        int   n;
        logic gap_bad, el_bad, drain_bad;
        n = 0;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        check({nm, " cmd_ready"}, cmd_ready, 1);
        cmd_valid = 1; cmd_len = LEN_W'(jb.len); cmd_shift = jb.sh; cmd_round = jb.rnd;
        cmd_saturate = jb.sat; cmd_subtract = jb.sub; cmd_unsigned_a = jb.ua; cmd_unsigned_b = jb.ub;
        tick();
        cmd_valid = 0;
        check({nm, " mode latch"},
              {busy, cmd_ready, op_ready, dsp_shift_right, dsp_round, dsp_saturate, dsp_subtract, dsp_unsigned_a, dsp_unsigned_b},
              {3'b101, jb.sh, jb.rnd, jb.sat, jb.sub, jb.ua, jb.ub});
        gap_bad = 0; el_bad = 0; drain_bad = 0;
        for (int i = 0; i < jb.len; i++) begin
            for (int g = 0; g < ((i == 0) ? 0 : jb.gap); g++) begin
                tick();
                if (dsp_load_acc !== 1'b0 || op_ready !== 1'b1) gap_bad = 1;
            end
            op_valid = 1; op_a1 = jb.a1[i]; op_a2 = jb.a2[i]; op_b1 = jb.b1[i]; op_b2 = jb.b2[i];
            if (op_ready !== 1'b1) el_bad = 1;
            tick();
            op_valid = 0;
            if (dsp_load_acc !== 1'b1 || dsp_a1 !== jb.a1[i] || dsp_a2 !== jb.a2[i] ||
                dsp_b1 !== jb.b1[i] || dsp_b2 !== jb.b2[i] ||
                dsp_feedback !== ((i == 0) ? 3'd1 : 3'd0)) el_bad = 1;
        end
        check({nm, " gap load_acc"}, gap_bad, 0);
        check({nm, " element drive"}, el_bad, 0);
        n = 0;
        while (!res_valid && n < 20) begin
            tick();
            n++;
            if (dsp_load_acc !== 1'b0 || op_ready !== 1'b0) drain_bad = 1;
        end
        check({nm, " latency"}, n, DSP_LATENCY + 1);
        check({nm, " drain quiet"}, drain_bad, 0);
        check({nm, " res_z1"}, res_z1, jb.z1);
        check({nm, " res_z2"}, res_z2, jb.z2);
        res_ready = 1;
        tick();
        res_ready = 0;
        check({nm, " back to idle"}, {res_valid, busy, cmd_ready}, 3'b001);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic ld_seen, rv_seen;

        tbl[0].len = 3; tbl[0].sh = 0; tbl[0].rnd = 0; tbl[0].sat = 0; tbl[0].sub = 0;
        tbl[0].ua = 1; tbl[0].ub = 1; tbl[0].gap = 0;
        tbl[0].a1 = '{10'd2, 10'd4, 10'd6, 10'd0}; tbl[0].b1 = '{9'd3, 9'd5, 9'd7, 9'd0};
        tbl[0].a2 = '{10'd1, 10'd1, 10'd1, 10'd0}; tbl[0].b2 = '{9'd1, 9'd1, 9'd1, 9'd0};
        tbl[0].z1 = 19'd68; tbl[0].z2 = 19'd3;
        tbl[1] = tbl[0]; tbl[1].gap = 2;
        tbl[2].len = 2; tbl[2].sh = 0; tbl[2].rnd = 0; tbl[2].sat = 0; tbl[2].sub = 1;
        tbl[2].ua = 0; tbl[2].ub = 0; tbl[2].gap = 0;
        tbl[2].a1 = '{10'h3FE, 10'h3FE, 10'd0, 10'd0}; tbl[2].b1 = '{9'd3, 9'd3, 9'd0, 9'd0};
        tbl[2].a2 = '{10'd0, 10'd0, 10'd0, 10'd0}; tbl[2].b2 = '{9'd0, 9'd0, 9'd0, 9'd0};
        tbl[2].z1 = 19'd12; tbl[2].z2 = 19'd0;
        tbl[3].len = 2; tbl[3].sh = 0; tbl[3].rnd = 0; tbl[3].sat = 1; tbl[3].sub = 0;
        tbl[3].ua = 1; tbl[3].ub = 1; tbl[3].gap = 0;
        tbl[3].a1 = '{10'd1023, 10'd1023, 10'd0, 10'd0}; tbl[3].b1 = '{9'd511, 9'd511, 9'd0, 9'd0};
        tbl[3].a2 = '{10'd0, 10'd0, 10'd0, 10'd0}; tbl[3].b2 = '{9'd0, 9'd0, 9'd0, 9'd0};
        tbl[3].z1 = 19'h7FFFF; tbl[3].z2 = 19'd0;
        tbl[4] = tbl[3]; tbl[4].sat = 0; tbl[4].sh = 5'd2; tbl[4].rnd = 1; tbl[4].z1 = 19'd261377;
        tbl[5].len = 4; tbl[5].sh = 0; tbl[5].rnd = 0; tbl[5].sat = 0; tbl[5].sub = 0;
        tbl[5].ua = 0; tbl[5].ub = 0; tbl[5].gap = 1;
        tbl[5].a1 = '{10'd3, 10'h3FC, 10'd7, 10'd1}; tbl[5].b1 = '{9'd5, 9'd6, 9'h1FE, 9'd1};
        tbl[5].a2 = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF}; tbl[5].b2 = '{9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF};
        tbl[5].z1 = 19'h7FFEA; tbl[5].z2 = 19'd4;

        // Reset state
        repeat (3) tick();
        RESET = 0;
        tick();
        check("reset handshake", {cmd_ready, op_ready, res_valid, busy}, 4'b1000);
        check("reset dsp data", {dsp_a1, dsp_a2, dsp_b1, dsp_b2}, 38'd0);
        check("reset dsp ctrl",
              {dsp_feedback, dsp_load_acc, dsp_acc_fir, dsp_shift_right, dsp_round, dsp_saturate,
               dsp_subtract, dsp_unsigned_a, dsp_unsigned_b},
              {3'd0, 1'b0, 5'd0, 5'd0, 3'b000, 2'b11});
        check("reset res_z", {res_z1, res_z2}, 38'd0);

        for (int k = 0; k < 6; k++) run_job(tbl[k], $sformatf("vec%0d", k));

        // Zero-length job: immediate empty result, held under back-pressure
        cmd_valid = 1; cmd_len = 0; cmd_shift = 0; cmd_round = 0; cmd_saturate = 0;
        cmd_subtract = 0; cmd_unsigned_a = 1; cmd_unsigned_b = 1;
        tick();
        cmd_valid = 0;
        ld_seen = dsp_load_acc;
        check("len0 res_valid", res_valid, 1);
        check("len0 res_z", {res_z1, res_z2}, 38'd0);
        for (int c = 0; c < 5; c++) begin
            tick();
            ld_seen = ld_seen | dsp_load_acc;
            check($sformatf("len0 hold c%0d", c), {res_valid, cmd_ready, busy, res_z1, res_z2}, {3'b101, 38'd0});
        end
        check("len0 no load_acc", ld_seen, 0);
        res_ready = 1;
        tick();
        res_ready = 0;
        check("len0 idle", {res_valid, busy, cmd_ready}, 3'b001);

        // Reset in the middle of a job
        cmd_valid = 1; cmd_len = 3; cmd_shift = 5'd4; cmd_round = 1; cmd_saturate = 1;
        cmd_subtract = 1; cmd_unsigned_a = 0; cmd_unsigned_b = 0;
        tick();
        cmd_valid = 0;
        op_valid = 1; op_a1 = 10'd5; op_b1 = 9'd5; op_a2 = 10'd7; op_b2 = 9'd7;
        tick();
        op_valid = 0;
        check("midrun accepted", {dsp_load_acc, busy}, 2'b11);
        RESET = 1;
        #1;
        check("midrun reset handshake", {cmd_ready, op_ready, res_valid, busy}, 4'b1000);
        check("midrun reset dsp",
              {dsp_a1, dsp_b1, dsp_feedback, dsp_load_acc, dsp_shift_right, dsp_round, dsp_saturate,
               dsp_subtract, dsp_unsigned_a, dsp_unsigned_b},
              {10'd0, 9'd0, 3'd0, 1'b0, 5'd0, 3'b000, 2'b11});
        tick();
        tick();
        RESET = 0;
        rv_seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            rv_seen = rv_seen | res_valid | busy;
        end
        check("midrun no result", rv_seen, 0);
        j.len = 1; j.sh = 0; j.rnd = 0; j.sat = 0; j.sub = 0; j.ua = 1; j.ub = 1; j.gap = 0;
        j.a1 = '{10'd3, 10'd0, 10'd0, 10'd0}; j.b1 = '{9'd4, 9'd0, 9'd0, 9'd0};
        j.a2 = '{10'd0, 10'd0, 10'd0, 10'd0}; j.b2 = '{9'd0, 9'd0, 9'd0, 9'd0};
        j.z1 = 19'd12; j.z2 = 19'd0;
        run_job(j, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
